dscmd_arbiter: RTL and testbench

- Sequences the downstream command bus (addr/data/request) shared by two requesters: the OpenHPSDR downstream unpacker and a local command source (e.g. power-up config sequencer).
- Converts the unpacker's toggle-style command strobe into buffered requests and arbitrates them round-robin against local requests.
- Issues single-cycle cmd_rqst pulses, honouring consumer back-pressure (cmd_busy) and a minimum inter-command gap.
- Sits between the unpacker and all command-bus consumers (radio regs, I2C, CWX and watchdog control).

---
 rtl/dscmd_arbiter_if.sv | 45 ++++
 rtl/dscmd_arbiter.sv | 149 ++++++++++++++
 tb/tb_dscmd_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dscmd_arbiter_if.sv
// ============================================================================
// Module      : dscmd_arbiter_if
// Description : Command-bus bundle between the unpacker, the local requester,
//               the dscmd_arbiter and the command-bus consumers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dscmd_arbiter_if;
    logic [5:0]  ds_cmd_addr;
    logic [31:0] ds_cmd_data;
    logic        ds_cmd_cnt;
    logic        ds_cmd_resprqst;
    logic        ds_cmd_is_alt;
    logic [5:0]  lcl_cmd_addr;
    logic [31:0] lcl_cmd_data;
    logic        lcl_cmd_req;
    logic        lcl_cmd_ack;
    logic        cmd_busy;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    logic        cmd_resprqst;
    logic        cmd_is_alt;
    logic        cmd_src;
    logic        ds_ovf;
    logic [7:0]  ds_ovf_cnt;
    logic        ovf_clr;

    modport slave (
        input  ds_cmd_addr, ds_cmd_data, ds_cmd_cnt, ds_cmd_resprqst, ds_cmd_is_alt,
        input  lcl_cmd_addr, lcl_cmd_data, lcl_cmd_req, cmd_busy, ovf_clr,
        output lcl_cmd_ack, cmd_addr, cmd_data, cmd_rqst, cmd_resprqst,
        output cmd_is_alt, cmd_src, ds_ovf, ds_ovf_cnt
    );

    modport master (
        output ds_cmd_addr, ds_cmd_data, ds_cmd_cnt, ds_cmd_resprqst, ds_cmd_is_alt,
        output lcl_cmd_addr, lcl_cmd_data, lcl_cmd_req, cmd_busy, ovf_clr,
        input  lcl_cmd_ack, cmd_addr, cmd_data, cmd_rqst, cmd_resprqst,
        input  cmd_is_alt, cmd_src, ds_ovf, ds_ovf_cnt
    );
endinterface

`default_nettype wire

// File: rtl/dscmd_arbiter.sv
// ============================================================================
// Module      : dscmd_arbiter
// Description : Buffers toggle-strobed downstream commands and round-robins
//               them against a local requester onto one command bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dscmd_arbiter #(
    parameter int DS_DEPTH = 4,
    parameter int GAP      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    dscmd_arbiter_if.slave  bus_io
);

    localparam int AW = $clog2(DS_DEPTH);
    localparam int EW = 40;
    localparam logic [3:0] GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t         state_q;
    logic [3:0]     gap_q;
    logic           cnt_q;
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]  mem_q [DS_DEPTH];
    logic           last_lcl_q;

    logic           rqst_q, ack_q, src_q, resp_q, alt_q;
    logic [5:0]     addr_q;
    logic [31:0]    data_q;
    logic           ovf_q;
    logic [7:0]     ovf_cnt_q;

    logic           w_push, w_pop, w_empty, w_full, w_wr_en, w_drop;
    logic           w_ds_pend, w_grant_lcl;
    logic [EW-1:0]  w_head;

    assign w_push  = (bus_io.ds_cmd_cnt != cnt_q);
    assign w_pop   = (state_q == S_ISSUE) && !src_q;
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;
    assign w_head  = mem_q[rd_ptr_q[AW-1:0]];

    assign w_ds_pend   = !w_empty;
    assign w_grant_lcl = bus_io.lcl_cmd_req && (!w_ds_pend || !last_lcl_q);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus_io.ds_cmd_addr, bus_io.ds_cmd_data,
                                        bus_io.ds_cmd_resprqst, bus_io.ds_cmd_is_alt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q <= bus_io.ds_cmd_cnt;
            if (w_wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else if (bus_io.ovf_clr) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else if (w_drop) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    // Outputs are loaded on the IDLE->ISSUE transition so they are live in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gap_q      <= 4'd0;
            last_lcl_q <= 1'b1;
            rqst_q     <= 1'b0;
            ack_q      <= 1'b0;
            src_q      <= 1'b0;
            resp_q     <= 1'b0;
            alt_q      <= 1'b0;
            addr_q     <= 6'd0;
            data_q     <= 32'd0;
        end else begin
            rqst_q <= 1'b0;
            ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!bus_io.cmd_busy && (w_ds_pend || bus_io.lcl_cmd_req)) begin
                        state_q    <= S_ISSUE;
                        rqst_q     <= 1'b1;
                        ack_q      <= w_grant_lcl;
                        src_q      <= w_grant_lcl;
                        last_lcl_q <= w_grant_lcl;
                        if (w_grant_lcl) begin
                            addr_q <= bus_io.lcl_cmd_addr;
                            data_q <= bus_io.lcl_cmd_data;
                            resp_q <= 1'b0;
                            alt_q  <= 1'b0;
                        end else begin
                            {addr_q, data_q, resp_q, alt_q} <= w_head;
                        end
                    end
                end
                S_ISSUE: begin
                    gap_q   <= GAP_INIT;
                    state_q <= (GAP == 0) ? S_IDLE : S_GAP;
                end
                S_GAP: begin
                    if (gap_q == 4'd0) state_q <= S_IDLE;
                    else               gap_q   <= gap_q - 4'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_io.cmd_rqst     = rqst_q;
    assign bus_io.lcl_cmd_ack  = ack_q;
    assign bus_io.cmd_src      = src_q;
    assign bus_io.cmd_resprqst = resp_q;
    assign bus_io.cmd_is_alt   = alt_q;
    assign bus_io.cmd_addr     = addr_q;
    assign bus_io.cmd_data     = data_q;
    assign bus_io.ds_ovf       = ovf_q;
    assign bus_io.ds_ovf_cnt   = ovf_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dscmd_arbiter.sv
// ============================================================================
// Module      : tb_dscmd_arbiter
// Description : Directed self-checking bench for dscmd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dscmd_arbiter;

    localparam int DS_DEPTH = 4;
    localparam int GAP      = 2;
    localparam int PERIOD   = GAP + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    dscmd_arbiter_if bus ();

    dscmd_arbiter #(.DS_DEPTH(DS_DEPTH), .GAP(GAP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue log captured mid-cycle on every strobe.
    logic [5:0]  l_addr [$];
    logic [31:0] l_data [$];
    logic        l_src  [$];
    logic        l_resp [$];
    logic        l_alt  [$];
    int          l_cyc  [$];
    int          ack_n  = 0;
    int          ack_cyc = -1;

    always @(negedge clk) begin
        if (bus.cmd_rqst) begin
            l_addr.push_back(bus.cmd_addr);
            l_data.push_back(bus.cmd_data);
            l_src.push_back(bus.cmd_src);
            l_resp.push_back(bus.cmd_resprqst);
            l_alt.push_back(bus.cmd_is_alt);
            l_cyc.push_back(cyc);
        end
        if (bus.lcl_cmd_ack) begin
            ack_n   = ack_n + 1;
            ack_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        l_addr.delete(); l_data.delete(); l_src.delete();
        l_resp.delete(); l_alt.delete(); l_cyc.delete();
        ack_n = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ds_push(input logic [5:0] a, input logic [31:0] d,
                           input logic resp, input logic alt);
        bus.ds_cmd_addr     = a;
        bus.ds_cmd_data     = d;
        bus.ds_cmd_resprqst = resp;
        bus.ds_cmd_is_alt   = alt;
        bus.ds_cmd_cnt      = ~bus.ds_cmd_cnt;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rqst"}, 64'(bus.cmd_rqst), 64'd0);
        chk({tag, "_addr"}, 64'(bus.cmd_addr), 64'd0);
        chk({tag, "_data"}, 64'(bus.cmd_data), 64'd0);
        chk({tag, "_misc"}, 64'({bus.cmd_src, bus.cmd_resprqst, bus.cmd_is_alt, bus.lcl_cmd_ack}), 64'd0);
        chk({tag, "_ovf"},  64'({bus.ds_ovf, bus.ds_ovf_cnt}), 64'd0);
    endtask

    initial begin
        bus.ds_cmd_addr = '0; bus.ds_cmd_data = '0; bus.ds_cmd_cnt = 1'b0;
        bus.ds_cmd_resprqst = 1'b0; bus.ds_cmd_is_alt = 1'b0;
        bus.lcl_cmd_addr = '0; bus.lcl_cmd_data = '0; bus.lcl_cmd_req = 1'b0;
        bus.cmd_busy = 1'b0; bus.ovf_clr = 1'b0;

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_all_zero("reset");

        // Single downstream command: strobe two cycles after the toggle
        clear_log();
        bus.ds_cmd_addr = 6'h0f; bus.ds_cmd_data = 32'h0100_0000;
        bus.ds_cmd_resprqst = 1'b1; bus.ds_cmd_is_alt = 1'b0;
        bus.ds_cmd_cnt = ~bus.ds_cmd_cnt;
        tick();
        chk("single_t1_rqst", 64'(bus.cmd_rqst), 64'd0);
        tick();
        chk("single_t2_rqst", 64'(bus.cmd_rqst), 64'd1);
        chk("single_addr",    64'(bus.cmd_addr), 64'h0f);
        chk("single_data",    64'(bus.cmd_data), 64'h0100_0000);
        chk("single_src",     64'(bus.cmd_src), 64'd0);
        chk("single_resp",    64'(bus.cmd_resprqst), 64'd1);
        tick();
        chk("single_pulse_end", 64'(bus.cmd_rqst), 64'd0);
        chk("single_addr_hold", 64'(bus.cmd_addr), 64'h0f);
        repeat (6) tick();
        chk("single_count", 64'(l_addr.size()), 64'd1);

        // Overflow: six pushes into a four-deep FIFO while busy
        clear_log();
        bus.cmd_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [2:0] iv;
            iv = 3'(i);
            ds_push(6'h10 + 6'(i), 32'(i) + 32'hA000_0000, 1'b0, iv[0]);
        end
        tick();
        chk("ovf_flag", 64'(bus.ds_ovf), 64'd1);
        chk("ovf_cnt",  64'(bus.ds_ovf_cnt), 64'd2);
        chk("ovf_no_issue_busy", 64'(l_addr.size()), 64'd0);
        bus.cmd_busy = 1'b0;
        repeat (25) tick();
        chk("ovf_issue_count", 64'(l_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < l_addr.size(); i++) begin
            logic [2:0] iv;
            iv = 3'(i);
            chk($sformatf("ovf_addr%0d", i), 64'(l_addr[i]), 64'(6'h10 + 6'(i)));
            chk($sformatf("ovf_data%0d", i), 64'(l_data[i]), 64'(32'(i) + 32'hA000_0000));
            chk($sformatf("ovf_alt%0d", i),  64'(l_alt[i]), 64'(iv[0]));
            if (i > 0)
                chk($sformatf("ovf_spacing%0d", i), 64'(l_cyc[i] - l_cyc[i-1]), 64'(PERIOD));
        end
        chk("ovf_flag_sticky", 64'(bus.ds_ovf), 64'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr_flag", 64'(bus.ds_ovf), 64'd0);
        chk("ovf_clr_cnt",  64'(bus.ds_ovf_cnt), 64'd0);

        // Back-pressure: one entry held off for 20 busy cycles
        clear_log();
        bus.cmd_busy = 1'b1;
        ds_push(6'h21, 32'hDEAD_0021, 1'b0, 1'b0);
        repeat (20) tick();
        chk("bp_no_issue", 64'(l_addr.size()), 64'd0);
        bus.cmd_busy = 1'b0;
        tick();
        chk("bp_rqst_after_fall", 64'(bus.cmd_rqst), 64'd1);
        chk("bp_addr", 64'(bus.cmd_addr), 64'h21);
        repeat (6) tick();

        // Full FIFO with a push landing in the ISSUE cycle
        clear_log();
        bus.cmd_busy = 1'b1;
        for (int i = 0; i < 4; i++) ds_push(6'h30 + 6'(i), 32'h3000 + 32'(i), 1'b0, 1'b0);
        tick();
        chk("full_no_ovf", 64'(bus.ds_ovf), 64'd0);
        bus.cmd_busy = 1'b0;
        tick();
        chk("full_issue_cycle", 64'(bus.cmd_rqst), 64'd1);
        ds_push(6'h34, 32'h3004, 1'b0, 1'b0);
        repeat (30) tick();
        chk("full_pop_ovf", 64'(bus.ds_ovf), 64'd0);
        chk("full_pop_count", 64'(l_addr.size()), 64'd5);
        for (int i = 0; i < 5 && i < l_addr.size(); i++)
            chk($sformatf("full_addr%0d", i), 64'(l_addr[i]), 64'(6'h30 + 6'(i)));

        // Reset mid-stream with three entries pending (toggle line back at 0)
        clear_log();
        bus.cmd_busy = 1'b1;
        for (int i = 0; i < 3; i++) ds_push(6'h20 + 6'(i), 32'h4000 + 32'(i), 1'b1, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        bus.cmd_busy = 1'b0;
        repeat (20) tick();
        chk("midrst_no_issue", 64'(l_addr.size()), 64'd0);

        // Local request withdrawn before it could be granted
        clear_log();
        bus.cmd_busy = 1'b1;
        bus.lcl_cmd_addr = 6'h22; bus.lcl_cmd_data = 32'h2222; bus.lcl_cmd_req = 1'b1;
        repeat (3) tick();
        bus.lcl_cmd_req = 1'b0;
        tick();
        bus.cmd_busy = 1'b0;
        repeat (8) tick();
        chk("withdraw_no_issue", 64'(l_addr.size()), 64'd0);
        chk("withdraw_no_ack", 64'(ack_n), 64'd0);

        // Round-robin: two DS entries against a held local request
        clear_log();
        bus.cmd_busy = 1'b1;
        ds_push(6'h05, 32'h0505, 1'b1, 1'b1);
        ds_push(6'h06, 32'h0606, 1'b1, 1'b1);
        bus.lcl_cmd_addr = 6'h39; bus.lcl_cmd_data = 32'h0000_CAFE; bus.lcl_cmd_req = 1'b1;
        tick();
        bus.cmd_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.lcl_cmd_ack) bus.lcl_cmd_req = 1'b0;
            tick();
        end
        chk("rr_count", 64'(l_addr.size()), 64'd3);
        if (l_addr.size() == 3) begin
            chk("rr_order_src",  64'({l_src[0], l_src[1], l_src[2]}), 64'b010);
            chk("rr_addr0", 64'(l_addr[0]), 64'h05);
            chk("rr_addr1", 64'(l_addr[1]), 64'h39);
            chk("rr_addr2", 64'(l_addr[2]), 64'h06);
            chk("rr_lcl_data", 64'(l_data[1]), 64'h0000_CAFE);
            chk("rr_lcl_resp_alt", 64'({l_resp[1], l_alt[1]}), 64'd0);
            chk("rr_ds_resp_alt",  64'({l_resp[0], l_alt[0]}), 64'b11);
            chk("rr_ack_cycle", 64'(ack_cyc), 64'(l_cyc[1]));
        end
        chk("rr_ack_once", 64'(ack_n), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
